// File: rtl/i2c_slave_byte_ctrl_pkg.sv
// Shared constants for the I2C target byte controller: FSM state codes
// (4-bit, legacy-compatible values) and bus-level ACK/NACK levels.
package i2c_slave_byte_ctrl_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_RX_BYTE   = 4'd3;
  localparam logic [3:0] ST_RX_ACK    = 4'd4;
  localparam logic [3:0] ST_TX_BYTE   = 4'd5;
  localparam logic [3:0] ST_TX_ACK    = 4'd6;
  localparam logic [3:0] ST_WAIT_STOP = 4'd7;

  // SDA level seen on the wire during the acknowledge clock
  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  function automatic logic addr_match(input logic [6:0] rx_addr,
                                      input logic [6:0] own_addr);
    return rx_addr == own_addr;
  endfunction

endpackage

// File: rtl/i2c_slave_byte_ctrl_bus_mon.sv
// Bus monitor: synchronises SCL/SDA, produces single-cycle SCL edge pulses
// and START/STOP condition pulses from the synchronised samples.
module i2c_slave_bus_mon #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Scl_i,
  input  logic Sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;

  // Idle bus is high, so flops reset to 1 to avoid phantom edges
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], Scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], Sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign sda       = sda_s;
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// I2C target byte controller: address match, byte receive/transmit with
// ACK handling, host-side single-cycle strobes.
module i2c_slave_byte_ctrl
  import i2c_slave_byte_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Scl_i,
  input  logic       Sda_i,
  output logic       Sda_oe,
  input  logic [6:0] Slv_addr,
  input  logic       Rx_ready,
  output logic [7:0] Rx_data,
  output logic       Rx_valid,
  input  logic [7:0] Tx_data,
  output logic       Tx_req,
  output logic       Master_ack,
  output logic       Addressed,
  output logic       Rw,
  output logic       Stop_det
);

  logic       scl_rise;
  logic       scl_fall;
  logic       sda;
  logic       bus_start;
  logic       bus_stop;

  logic [3:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       tx_load;
  logic       ack_phase;
  logic       nack_pend;

  i2c_slave_bus_mon #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_mon (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Scl_i     (Scl_i),
    .Sda_i     (Sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda       (sda),
    .start_det (bus_start),
    .stop_det  (bus_stop)
  );

  // ack_phase marks "9th rise seen" so the 8th and 9th falls can be told apart
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      tx_load    <= 1'b0;
      ack_phase  <= 1'b0;
      nack_pend  <= 1'b0;
      Sda_oe     <= 1'b0;
      Rx_data    <= '0;
      Rx_valid   <= 1'b0;
      Tx_req     <= 1'b0;
      Master_ack <= 1'b0;
      Addressed  <= 1'b0;
      Rw         <= 1'b0;
      Stop_det   <= 1'b0;
    end else begin
      Rx_valid <= 1'b0;
      Tx_req   <= 1'b0;
      Stop_det <= 1'b0;
      tx_load  <= Tx_req;
      if (tx_load) begin
        shift <= Tx_data;
      end

      if (bus_start) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        shift     <= '0;
        Addressed <= 1'b0;
        Sda_oe    <= 1'b0;
        ack_phase <= 1'b0;
        nack_pend <= 1'b0;
      end else if (bus_stop) begin
        state     <= ST_IDLE;
        Sda_oe    <= 1'b0;
        Stop_det  <= Addressed;
        Addressed <= 1'b0;
        ack_phase <= 1'b0;
        nack_pend <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
          end

          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (addr_match(shift[6:0], Slv_addr)) begin
                  Rw        <= sda;
                  Addressed <= 1'b1;
                  ack_phase <= 1'b0;
                  state     <= ST_ADDR_ACK;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_rise) begin
              ack_phase <= 1'b1;
              if (Rw) begin
                Tx_req <= 1'b1;
              end
            end else if (scl_fall) begin
              if (!ack_phase) begin
                Sda_oe <= ~SDA_ACK;
              end else begin
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                if (Rw) begin
                  Sda_oe <= ~shift[7];
                  shift  <= {shift[6:0], 1'b0};
                  state  <= ST_TX_BYTE;
                end else begin
                  Sda_oe <= 1'b0;
                  state  <= ST_RX_BYTE;
                end
              end
            end
          end

          ST_RX_BYTE: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                Rx_data   <= {shift[6:0], sda};
                Rx_valid  <= 1'b1;
                ack_phase <= 1'b0;
                if (Rx_ready) begin
                  state <= ST_RX_ACK;
                end else begin
                  nack_pend <= 1'b1;
                  state     <= ST_WAIT_STOP;
                end
              end
            end
          end

          ST_RX_ACK: begin
            if (scl_rise) begin
              ack_phase <= 1'b1;
            end else if (scl_fall) begin
              if (!ack_phase) begin
                Sda_oe <= ~SDA_ACK;
              end else begin
                Sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                state     <= ST_RX_BYTE;
              end
            end
          end

          // Entered on the fall that drove bit7; bit_cnt wraps to 0 after the 8th rise
          ST_TX_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                Sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                state     <= ST_TX_ACK;
              end else begin
                Sda_oe <= ~shift[7];
                shift  <= {shift[6:0], 1'b0};
              end
            end
          end

          ST_TX_ACK: begin
            if (scl_rise && !ack_phase) begin
              Master_ack <= (sda == SDA_ACK);
              if (sda == SDA_ACK) begin
                Tx_req    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                Sda_oe    <= 1'b0;
                Addressed <= 1'b0;
                state     <= ST_WAIT_STOP;
              end
            end else if (scl_fall && ack_phase) begin
              Sda_oe    <= ~shift[7];
              shift     <= {shift[6:0], 1'b0};
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
              state     <= ST_TX_BYTE;
            end
          end

          // After a host-side NACK, Addressed holds until the 9th clock completes
          ST_WAIT_STOP: begin
            Sda_oe <= 1'b0;
            if (nack_pend) begin
              if (scl_rise) begin
                ack_phase <= 1'b1;
              end else if (scl_fall && ack_phase) begin
                Addressed <= 1'b0;
                nack_pend <= 1'b0;
                ack_phase <= 1'b0;
              end
            end
          end

          default: begin
            state  <= ST_IDLE;
            Sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Self-checking bench: behavioural I2C master on a wired-AND SDA, with
// directed and randomised transfers checked against transaction-level rules.
module tb_i2c_slave_byte_ctrl;

  localparam int unsigned Q = 8;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       Sda_oe;
  logic [6:0] Slv_addr;
  logic       Rx_ready;
  logic [7:0] Rx_data;
  logic       Rx_valid;
  logic [7:0] Tx_data;
  logic       Tx_req;
  logic       Master_ack;
  logic       Addressed;
  logic       Rw;
  logic       Stop_det;

  int checks = 0;
  int errors = 0;

  logic [7:0] rxq[$];
  int txreq_cnt = 0;
  int stop_cnt  = 0;
  int oe_cnt    = 0;

  assign sda_bus = sda_m & ~Sda_oe;

  always #5 Clk = ~Clk;

  i2c_slave_byte_ctrl #(.SYNC_STAGES(2)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Scl_i      (scl),
    .Sda_i      (sda_bus),
    .Sda_oe     (Sda_oe),
    .Slv_addr   (Slv_addr),
    .Rx_ready   (Rx_ready),
    .Rx_data    (Rx_data),
    .Rx_valid   (Rx_valid),
    .Tx_data    (Tx_data),
    .Tx_req     (Tx_req),
    .Master_ack (Master_ack),
    .Addressed  (Addressed),
    .Rw         (Rw),
    .Stop_det   (Stop_det)
  );

  always @(negedge Clk) begin
    if (Rx_valid) rxq.push_back(Rx_data);
    if (Tx_req)   txreq_cnt <= txreq_cnt + 1;
    if (Stop_det) stop_cnt  <= stop_cnt + 1;
    if (Sda_oe)   oe_cnt    <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge Clk);
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    sda_m = b;
    wait_q();
    scl = 1'b1;
    wait_q();
    s = sda_bus;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
    xfer_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, s);
      d[i] = s;
    end
    Tx_data = next_tx;
    xfer_bit(~mack, s);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] tx0;
    int         base;
    int         sb;
    int         ob;
    int         tb0;
    logic [6:0] own;
    logic [6:0] tgt;
    logic       exp_addr;
    logic       rr;
    logic [7:0] exp_rx[$];

    Rst_n = 1'b0; Slv_addr = 7'h42; Rx_ready = 1'b1; Tx_data = 8'h00;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    check("reset_outputs", 32'({Sda_oe, Rx_data, Rx_valid, Tx_req, Master_ack, Addressed, Rw, Stop_det}), 32'd0);
    Rst_n = 1'b1;
    repeat (4) @(posedge Clk);

    // master write 0x42/W, A5, 3C
    base = rxq.size(); sb = stop_cnt;
    bus_start();
    send_byte({7'h42, 1'b0}, ack);  check("wr_addr_ack", 32'(ack), 32'd1);
    check("wr_addressed", 32'(Addressed), 32'd1);
    check("wr_rw", 32'(Rw), 32'd0);
    send_byte(8'hA5, ack);          check("wr_d0_ack", 32'(ack), 32'd1);
    send_byte(8'h3C, ack);          check("wr_d1_ack", 32'(ack), 32'd1);
    bus_stop();
    check("wr_rx_count", 32'(rxq.size() - base), 32'd2);
    if (rxq.size() - base == 2) begin
      check("wr_rx0", 32'(rxq[base]), 32'h A5);
      check("wr_rx1", 32'(rxq[base+1]), 32'h3C);
    end
    check("wr_stop_det", 32'(stop_cnt - sb), 32'd1);
    check("wr_addressed_end", 32'(Addressed), 32'd0);

    // address mismatch
    base = rxq.size(); sb = stop_cnt; ob = oe_cnt;
    bus_start();
    send_byte({7'h43, 1'b0}, ack);  check("mm_addr_nack", 32'(ack), 32'd0);
    check("mm_addressed", 32'(Addressed), 32'd0);
    send_byte(8'h5A, ack);          check("mm_data_nack", 32'(ack), 32'd0);
    bus_stop();
    check("mm_oe_never", 32'(oe_cnt - ob), 32'd0);
    check("mm_no_rx", 32'(rxq.size() - base), 32'd0);
    check("mm_no_stop_det", 32'(stop_cnt - sb), 32'd0);

    // master read 0x96 (ACK), 0x0F (NACK)
    sb = stop_cnt; tb0 = txreq_cnt; Tx_data = 8'h96;
    bus_start();
    send_byte({7'h42, 1'b1}, ack);  check("rd_addr_ack", 32'(ack), 32'd1);
    check("rd_rw", 32'(Rw), 32'd1);
    read_byte(1'b1, 8'h0F, d);      check("rd_byte0", 32'(d), 32'h96);
    check("rd_mack0", 32'(Master_ack), 32'd1);
    read_byte(1'b0, 8'hEE, d);      check("rd_byte1", 32'(d), 32'h0F);
    check("rd_mack1", 32'(Master_ack), 32'd0);
    check("rd_txreq", 32'(txreq_cnt - tb0), 32'd2);
    check("rd_addressed_nack", 32'(Addressed), 32'd0);
    ob = oe_cnt;
    read_byte(1'b0, 8'h00, d);      check("rd_wait_stop_idle", 32'(d), 32'hFF);
    check("rd_wait_stop_oe", 32'(oe_cnt - ob), 32'd0);
    bus_stop();
    check("rd_no_stop_det", 32'(stop_cnt - sb), 32'd0);

    // repeated START mid-byte
    base = rxq.size();
    bus_start();
    send_byte({7'h42, 1'b0}, ack);  check("rs_addr_ack", 32'(ack), 32'd1);
    xfer_bit(1'b1, ack); xfer_bit(1'b0, ack); xfer_bit(1'b1, ack); xfer_bit(1'b1, ack);
    tx0 = 8'($urandom); Tx_data = tx0; tb0 = txreq_cnt;
    sda_m = 1'b1; wait_q(); scl = 1'b1; wait_q(); sda_m = 1'b0; wait_q();
    check("rs_oe_released", 32'(Sda_oe), 32'd0);
    check("rs_addressed_drop", 32'(Addressed), 32'd0);
    scl = 1'b0; wait_q();
    send_byte({7'h42, 1'b1}, ack);  check("rs_reack", 32'(ack), 32'd1);
    check("rs_rw", 32'(Rw), 32'd1);
    check("rs_txreq", 32'(txreq_cnt - tb0), 32'd1);
    read_byte(1'b0, 8'h00, d);      check("rs_read", 32'(d), 32'(tx0));
    check("rs_no_rx", 32'(rxq.size() - base), 32'd0);
    bus_stop();

    // host not ready -> NACK of 0x55
    base = rxq.size(); sb = stop_cnt;
    bus_start();
    send_byte({7'h42, 1'b0}, ack);  check("nr_addr_ack", 32'(ack), 32'd1);
    Rx_ready = 1'b0;
    send_byte(8'h55, ack);          check("nr_nack", 32'(ack), 32'd0);
    check("nr_addressed", 32'(Addressed), 32'd0);
    Rx_ready = 1'b1;
    send_byte(8'h12, ack);          check("nr_later_nack", 32'(ack), 32'd0);
    bus_stop();
    check("nr_rx_count", 32'(rxq.size() - base), 32'd1);
    if (rxq.size() - base == 1) check("nr_rx_data", 32'(rxq[base]), 32'h55);
    check("nr_no_stop_det", 32'(stop_cnt - sb), 32'd0);

    // reset while driving the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) xfer_bit(((8'h84 >> i) & 8'h01) != 8'h00, ack);
    check("rst_pre_oe", 32'(Sda_oe), 32'd1);
    @(negedge Clk); Rst_n = 1'b0;
    @(posedge Clk); #1;
    check("rst_oe", 32'(Sda_oe), 32'd0);
    check("rst_outputs", 32'({Rx_data, Rx_valid, Tx_req, Master_ack, Addressed, Rw, Stop_det}), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk); Rst_n = 1'b1;
    bus_start();
    send_byte({7'h42, 1'b0}, ack);  check("rst_after_ack", 32'(ack), 32'd1);
    check("rst_after_addressed", 32'(Addressed), 32'd1);
    bus_stop();

    // randomised writes: ACK iff address matches and host ready; NACK ends addressing
    for (int t = 0; t < 6; t++) begin
      own = 7'($urandom_range(1, 127));
      Slv_addr = own;
      tgt = ($urandom_range(0, 1) == 1) ? own : 7'(own + 7'($urandom_range(1, 127)));
      exp_addr = (tgt == own);
      exp_rx.delete();
      base = rxq.size(); sb = stop_cnt;
      bus_start();
      send_byte({tgt, 1'b0}, ack);  check("rnd_addr_ack", 32'(ack), 32'(exp_addr));
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        d = 8'($urandom);
        rr = 1'($urandom_range(0, 1));
        Rx_ready = rr;
        send_byte(d, ack);
        check("rnd_data_ack", 32'(ack), 32'(exp_addr & rr));
        if (exp_addr) exp_rx.push_back(d);
        if (!rr) exp_addr = 1'b0;
      end
      bus_stop();
      check("rnd_stop_det", 32'(stop_cnt - sb), 32'(exp_addr));
      check("rnd_rx_count", 32'(rxq.size() - base), 32'(exp_rx.size()));
      if (rxq.size() - base == exp_rx.size())
        for (int k = 0; k < exp_rx.size(); k++) check("rnd_rx_data", 32'(rxq[base+k]), 32'(exp_rx[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
